// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 24;

    // Port indices; also used as the owner / last-winner encoding
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// rtl/mem_arbiter_arb_pick.sv - combinational two-input winner selector (MEM_ARBITER_ROUND_ROBIN_EN selects round-robin)
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_f_req,
    input  logic       i_d_req,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    input  logic       i_prefer_d,
`endif
    output logic [1:0] o_win
);

    // One-hot winner; on contention the preferred port (or D, in fixed mode) wins
    always_comb begin
        o_win = 2'b00;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (i_f_req && i_d_req) begin
            if (i_prefer_d) begin
                o_win[PORT_D] = 1'b1;
            end else begin
                o_win[PORT_F] = 1'b1;
            end
        end else if (i_d_req) begin
            o_win[PORT_D] = 1'b1;
        end else if (i_f_req) begin
            o_win[PORT_F] = 1'b1;
        end
`else
        if (i_d_req) begin
            o_win[PORT_D] = 1'b1;
        end else if (i_f_req) begin
            o_win[PORT_F] = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port access sequencer for a single-port sync-read memory (MEM_ARBITER_ROUND_ROBIN_EN selects round-robin)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_f_req,
    input  logic              i_f_we,
    input  logic [ADDR_W-1:0] i_f_addr,
    input  logic [DATA_W-1:0] i_f_wdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_f_gnt,
    output logic              o_f_rvalid,
    output logic [DATA_W-1:0] o_f_rdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_write_enable,
    output logic [DATA_W-1:0] o_mem_in,
    input  logic [DATA_W-1:0] i_mem_out
);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        w_win;
    logic              w_take;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Last winner; reset to D so that F is preferred first
    logic              r_rr_last;

    arb_pick u_pick (
        .i_f_req    (i_f_req),
        .i_d_req    (i_d_req),
        .i_prefer_d (r_rr_last == PORT_F),
        .o_win      (w_win)
    );
`else
    arb_pick u_pick (
        .i_f_req (i_f_req),
        .i_d_req (i_d_req),
        .o_win   (w_win)
    );
`endif

    // Requests are only considered while idle; a req left high rearbitrates there
    assign w_take = (r_state == ST_IDLE) && (|w_win);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        w_next             = r_state;
        o_f_gnt            = 1'b0;
        o_d_gnt            = 1'b0;
        o_f_rvalid         = 1'b0;
        o_d_rvalid         = 1'b0;
        o_mem_write_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_f_gnt            = (r_owner == PORT_F);
                o_d_gnt            = (r_owner == PORT_D);
                o_mem_write_enable = r_we;
                w_next             = ST_RESP;
            end
            ST_RESP: begin
                o_f_rvalid = (r_owner == PORT_F);
                o_d_rvalid = (r_owner == PORT_D);
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's request fields; they drive the memory until the next win
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner <= PORT_F;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_take) begin
            if (w_win[PORT_D]) begin
                r_owner <= PORT_D;
                r_we    <= i_d_we;
                r_addr  <= i_d_addr;
                r_wdata <= i_d_wdata;
            end else begin
                r_owner <= PORT_F;
                r_we    <= i_f_we;
                r_addr  <= i_f_addr;
                r_wdata <= i_f_wdata;
            end
        end
    end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Round-robin pointer follows each grant decision
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_last <= PORT_D;
        end else if (w_take) begin
            r_rr_last <= w_win[PORT_D] ? PORT_D : PORT_F;
        end
    end
`endif

    assign o_busy        = (r_state != ST_IDLE);
    assign o_mem_address = r_addr;
    assign o_mem_in      = r_wdata;
    assign o_f_rdata     = i_mem_out;
    assign o_d_rdata     = i_mem_out;

endmodule
